// File: rtl/everloop_pkg.sv
// Shared types and 50 MHz default timing for the everloop LED ring.
// The LED count and bytes-per-LED defaults are also used to size the frame RAM.
package everloop_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, BIT, LATCH} state_t;

  localparam int EVL_NUM_LEDS      = 35;
  localparam int EVL_BYTES_PER_LED = 4;
  localparam int EVL_BIT_CYCLES    = 63;    // 1.25 us
  localparam int EVL_T0H_CYCLES    = 18;
  localparam int EVL_T1H_CYCLES    = 35;
  localparam int EVL_RESET_CYCLES  = 4000;  // 80 us latch gap

endpackage

// File: rtl/everloop_bit_timer.sv
// WS2812 bit-period timer. It works one cycle ahead: run/bit_val describe the
// coming cycle, so ws is a flop that is already correct in the first cycle of
// a bit. first_cycle flags that the coming cycle opens a new bit period.
module everloop_bit_timer #(
  parameter int BIT_CYCLES = 63,
  parameter int T0H_CYCLES = 18,
  parameter int T1H_CYCLES = 35
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic bit_val,
  output logic ws,
  output logic bit_end,
  output logic first_cycle
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_n;
  logic          active_q;
  logic          ws_n;

  // Next bit phase and the line level that phase produces.
  always_comb begin
    cnt_n = '0;
    if (run && active_q && (cnt_q != CW'(BIT_CYCLES - 1)))
      cnt_n = cnt_q + CW'(1);
    ws_n = run && (int'(cnt_n) < (bit_val ? T1H_CYCLES : T0H_CYCLES));
  end

  assign bit_end     = active_q && (cnt_q == CW'(BIT_CYCLES - 1));
  assign first_cycle = run && (cnt_n == '0);

  // Phase counter and registered line level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      ws       <= 1'b0;
    end else begin
      cnt_q    <= cnt_n;
      active_q <= run;
      ws       <= ws_n;
    end
  end

endmodule

// File: rtl/everloop_ws2812_driver.sv
// Everloop WS2812/SK6812 ring driver: reads the LED frame RAM byte by byte,
// shifts each byte out MSB first, then holds the line low for the latch gap.
// The next byte is prefetched during bit 0 so bytes follow with no gap.
// Build option EVERLOOP_AUTO_REFRESH_EN: frames repeat back-to-back from reset
// release and start is ignored.
module everloop_ws2812_driver
  import everloop_pkg::*;
#(
  parameter int NUM_LEDS      = EVL_NUM_LEDS,
  parameter int BYTES_PER_LED = EVL_BYTES_PER_LED,
  parameter int BIT_CYCLES    = EVL_BIT_CYCLES,
  parameter int T0H_CYCLES    = EVL_T0H_CYCLES,
  parameter int T1H_CYCLES    = EVL_T1H_CYCLES,
  parameter int RESET_CYCLES  = EVL_RESET_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic       ram_en,
  output logic [7:0] ram_adr,
  input  logic [7:0] ram_dat,
  output logic       ws_out,
  output logic       busy,
  output logic       frame_done
);
  localparam int TOTAL = NUM_LEDS * BYTES_PER_LED;
  localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int LW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  if (TOTAL > 256) begin : g_err_total
    $error("everloop: NUM_LEDS*BYTES_PER_LED exceeds the 8-bit RAM address space");
  end
  if (T1H_CYCLES >= BIT_CYCLES) begin : g_err_t1h
    $error("everloop: T1H_CYCLES must be below BIT_CYCLES");
  end
  if (T0H_CYCLES >= T1H_CYCLES) begin : g_err_t0h
    $error("everloop: T0H_CYCLES must be below T1H_CYCLES");
  end
  if (RESET_CYCLES < 2) begin : g_err_rst
    // frame_done is raised one cycle ahead from the latch counter
    $error("everloop: RESET_CYCLES must be at least 2");
  end

  state_t        state_q, state_n;
  logic [BW-1:0] byte_q, byte_n;
  logic [2:0]    bit_idx_q, bit_idx_n;
  logic [7:0]    shift_q, shift_n;
  logic [7:0]    pf_q;
  logic          pf_pend_q;
  logic [LW-1:0] lat_q, lat_n;
  logic          busy_n, done_n;
  logic          ram_en_n;
  logic [7:0]    ram_adr_n;
  logic          run, bit_end, first_cycle;

`ifdef EVERLOOP_AUTO_REFRESH_EN
  logic unused_start;
  assign unused_start = start;
`endif

  // Frame sequencing: next state, byte/bit position and shift data.
  always_comb begin
    state_n   = state_q;
    byte_n    = byte_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    lat_n     = lat_q;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef EVERLOOP_AUTO_REFRESH_EN
        state_n = FETCH;
        busy_n  = 1'b1;
`else
        if (start) begin
          state_n = FETCH;
          busy_n  = 1'b1;
        end
`endif
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n   = ram_dat;
        bit_idx_n = 3'd7;
        byte_n    = '0;
        state_n   = BIT;
      end
      BIT: begin
        if (bit_end) begin
          if (bit_idx_q != 3'd0) begin
            shift_n   = {shift_q[6:0], 1'b0};
            bit_idx_n = bit_idx_q - 3'd1;
          end else if (int'(byte_q) == TOTAL - 1) begin
            state_n = LATCH;
            lat_n   = '0;
          end else begin
            shift_n   = pf_q;
            bit_idx_n = 3'd7;
            byte_n    = byte_q + BW'(1);
          end
        end
      end
      LATCH: begin
        done_n = (int'(lat_q) == RESET_CYCLES - 2);
        if (int'(lat_q) == RESET_CYCLES - 1) begin
`ifdef EVERLOOP_AUTO_REFRESH_EN
          state_n = FETCH;
`else
          state_n = IDLE;
          busy_n  = 1'b0;
`endif
        end else begin
          lat_n = lat_q + LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign run = (state_n == BIT);

  // RAM read requests: the initial fetch, then one prefetch as bit 0 opens.
  always_comb begin
    ram_en_n  = 1'b0;
    ram_adr_n = ram_adr;
    if (state_n == FETCH) begin
      ram_en_n  = 1'b1;
      ram_adr_n = '0;
    end else if (run && first_cycle && (bit_idx_n == 3'd0) &&
                 (int'(byte_n) < TOTAL - 1)) begin
      ram_en_n  = 1'b1;
      ram_adr_n = 8'(byte_n) + 8'd1;
    end
  end

  everloop_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_bit_timer (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .bit_val     (shift_n[7]),
    .ws          (ws_out),
    .bit_end     (bit_end),
    .first_cycle (first_cycle)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      pf_q       <= '0;
      pf_pend_q  <= 1'b0;
      lat_q      <= '0;
      ram_en     <= 1'b0;
      ram_adr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      byte_q     <= byte_n;
      bit_idx_q  <= bit_idx_n;
      shift_q    <= shift_n;
      lat_q      <= lat_n;
      ram_en     <= ram_en_n;
      ram_adr    <= ram_adr_n;
      busy       <= busy_n;
      frame_done <= done_n;
      // RAM data for a prefetch arrives the cycle after its read enable
      pf_pend_q  <= ram_en && (state_q == BIT);
      if (pf_pend_q) pf_q <= ram_dat;
    end
  end

endmodule
